// File: rtl/fibonacci.sv
// rtl/fibonacci.sv - Fibonacci-number detector with registered flag and saturating hit counter
// Optional FIBONACCI_INDEX_EN adds fib_idx / fib_idx_q (sequence index of the operand).
module fibonacci #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  output logic             out,
  output logic             out_q,
  output logic             out_q_vld,
  output logic [CNT_W-1:0] hit_cnt
`ifdef FIBONACCI_INDEX_EN
  ,
  output logic [4:0]       fib_idx,
  output logic [4:0]       fib_idx_q
`endif
);

  // F24 = 46368 is the largest term that fits the widest legal operand.
  localparam int NFIB = 25;
  localparam int MAXV = (1 << WIDTH) - 1;

  function automatic int fib_at(input int n);
    int a;
    int b;
    int t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  logic [NFIB-1:0] hit;

  for (genvar n = 0; n < NFIB; n++) begin : g_fib
    localparam int FV = fib_at(n);
    if (FV <= MAXV) begin : g_cmp
      assign hit[n] = (in == WIDTH'(FV));
    end else begin : g_none
      assign hit[n] = 1'b0;
    end
  end

  assign out = |hit;

  logic             out_d;
  logic             vld_q;
  logic             vld_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    out_d = out_q;
    vld_d = in_vld;
    cnt_d = cnt_q;
    if (in_vld) begin
      out_d = out;
      if (out && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_q_vld = vld_q;
  assign hit_cnt   = cnt_q;

`ifdef FIBONACCI_INDEX_EN
  logic [4:0] idx_d;
  logic [4:0] idx_q;

  // Scan downward so the lowest matching index wins (1 maps to n=1, not n=2).
  always_comb begin
    fib_idx = 5'd0;
    for (int n = NFIB - 1; n >= 0; n--) begin
      if (hit[n]) begin
        fib_idx = 5'(n);
      end
    end
    idx_d = in_vld ? fib_idx : idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= 5'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign fib_idx_q = idx_q;
`endif

endmodule

// File: tb/tb_fibonacci.sv
// tb/tb_fibonacci.sv - self-checking bench for fibonacci (WIDTH=4, saturating CNT_W=3, WIDTH=8 instances)
module tb_fibonacci;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] in4;
  logic       v4;
  logic       o4, oq4, ov4;
  logic [7:0] c4;
  logic [3:0] ins;
  logic       vs;
  logic       os, oqs, ovs;
  logic [2:0] cs;
  logic [7:0] in8;
  logic       v8;
  logic       o8, oq8, ov8;
  logic [7:0] c8;
`ifdef FIBONACCI_INDEX_EN
  logic [4:0] fi4, fiq4, fis, fiqs, fi8, fiq8;
`endif

  fibonacci #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in4), .in_vld(v4),
    .out(o4), .out_q(oq4), .out_q_vld(ov4), .hit_cnt(c4)
`ifdef FIBONACCI_INDEX_EN
    , .fib_idx(fi4), .fib_idx_q(fiq4)
`endif
  );

  fibonacci #(.WIDTH(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in(ins), .in_vld(vs),
    .out(os), .out_q(oqs), .out_q_vld(ovs), .hit_cnt(cs)
`ifdef FIBONACCI_INDEX_EN
    , .fib_idx(fis), .fib_idx_q(fiqs)
`endif
  );

  fibonacci #(.WIDTH(8), .CNT_W(8)) dut_w8 (
    .clk(clk), .rst(rst), .in(in8), .in_vld(v8),
    .out(o8), .out_q(oq8), .out_q_vld(ov8), .hit_cnt(c8)
`ifdef FIBONACCI_INDEX_EN
    , .fib_idx(fi8), .fib_idx_q(fiq8)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for the WIDTH=4 / CNT_W=8 instance.
  bit m_oq;
  int m_cnt;
  int m_idxq;

  function automatic bit is_fib(input int v);
    int a, b, t;
    a = 0;
    b = 1;
    while (a < v) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a == v;
  endfunction

  function automatic int fib_index(input int v);
    int a, b, t, n;
    a = 0;
    b = 1;
    n = 0;
    while (a < v) begin
      t = a + b;
      a = b;
      b = t;
      n++;
    end
    return (a == v) ? n : 0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    in4 = 4'd5; v4 = 1'b1;
    ins = 4'd0; vs = 1'b0;
    in8 = 8'd0; v8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (oq4 !== 1'b0) $display("FAIL reset_out_q got %b want 0", oq4); else n_pass++;
    n_checks++; if (ov4 !== 1'b0) $display("FAIL reset_out_q_vld got %b want 0", ov4); else n_pass++;
    n_checks++; if (c4 !== 8'd0) $display("FAIL reset_hit_cnt got %0d want 0", c4); else n_pass++;
    n_checks++; if (o4 !== 1'b1) $display("FAIL reset_comb_out got %b want 1", o4); else n_pass++;
    n_checks++; if (cs !== 3'd0 || c8 !== 8'd0) $display("FAIL reset_other_cnt got %0d/%0d want 0/0", cs, c8); else n_pass++;
    @(negedge clk);
    v4 = 1'b0;
    rst = 1'b1;
    m_oq = 1'b0; m_cnt = 0; m_idxq = 0;
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      in4 = 4'(v); v4 = 1'b1;
      #1;
      n_checks++; if (o4 !== is_fib(v)) $display("FAIL sweep_out in=%0d got %b want %b", v, o4, is_fib(v)); else n_pass++;
      @(posedge clk);
      #1;
      m_oq = is_fib(v);
      if (m_oq && m_cnt < 255) m_cnt++;
      n_checks++; if (oq4 !== m_oq) $display("FAIL sweep_out_q in=%0d got %b want %b", v, oq4, m_oq); else n_pass++;
      n_checks++; if (ov4 !== 1'b1) $display("FAIL sweep_vld in=%0d got %b want 1", v, ov4); else n_pass++;
      n_checks++; if (c4 !== 8'(m_cnt)) $display("FAIL sweep_cnt in=%0d got %0d want %0d", v, c4, m_cnt); else n_pass++;
    end
    n_checks++; if (c4 !== 8'd7) $display("FAIL sweep_total got %0d want 7", c4); else n_pass++;
  endtask

  task automatic test_hold();
    @(negedge clk);
    in4 = 4'd4; v4 = 1'b0;
    #1;
    n_checks++; if (o4 !== 1'b0) $display("FAIL hold_out got %b want 0", o4); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_checks++; if (oq4 !== m_oq) $display("FAIL hold_out_q cyc=%0d got %b want %b", k, oq4, m_oq); else n_pass++;
      n_checks++; if (ov4 !== 1'b0) $display("FAIL hold_vld cyc=%0d got %b want 0", k, ov4); else n_pass++;
      n_checks++; if (c4 !== 8'(m_cnt)) $display("FAIL hold_cnt cyc=%0d got %0d want %0d", k, c4, m_cnt); else n_pass++;
    end
  endtask

  task automatic test_random();
    int v;
    bit vl;
    for (int k = 0; k < 60; k++) begin
      v  = int'($urandom_range(0, 15));
      vl = 1'($urandom_range(0, 1));
      @(negedge clk);
      in4 = 4'(v); v4 = vl;
      #1;
      n_checks++; if (o4 !== is_fib(v)) $display("FAIL rand_out in=%0d got %b want %b", v, o4, is_fib(v)); else n_pass++;
      @(posedge clk);
      #1;
      if (vl) begin
        m_oq = is_fib(v);
        if (m_oq && m_cnt < 255) m_cnt++;
      end
      n_checks++; if (oq4 !== m_oq) $display("FAIL rand_out_q in=%0d got %b want %b", v, oq4, m_oq); else n_pass++;
      n_checks++; if (ov4 !== vl) $display("FAIL rand_vld got %b want %b", ov4, vl); else n_pass++;
      n_checks++; if (c4 !== 8'(m_cnt)) $display("FAIL rand_cnt got %0d want %0d", c4, m_cnt); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int vals[5] = '{1, 2, 3, 5, 8};
    @(negedge clk);
    v4 = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    foreach (vals[i]) begin
      @(negedge clk);
      in4 = 4'(vals[i]); v4 = 1'b1;
    end
    @(negedge clk);
    in4 = 4'd8; v4 = 1'b0;
    n_checks++; if (c4 !== 8'd5) $display("FAIL arst_precount got %0d want 5", c4); else n_pass++;
    n_checks++; if (oq4 !== 1'b1) $display("FAIL arst_pre_out_q got %b want 1", oq4); else n_pass++;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++; if (c4 !== 8'd0) $display("FAIL arst_cnt got %0d want 0", c4); else n_pass++;
    n_checks++; if (oq4 !== 1'b0) $display("FAIL arst_out_q got %b want 0", oq4); else n_pass++;
    n_checks++; if (ov4 !== 1'b0) $display("FAIL arst_vld got %b want 0", ov4); else n_pass++;
    n_checks++; if (o4 !== 1'b1) $display("FAIL arst_comb_out got %b want 1", o4); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (o4 !== 1'b1 || c4 !== 8'd0) $display("FAIL arst_hold out=%b cnt=%0d want 1/0", o4, c4); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    m_oq = 1'b0; m_cnt = 0; m_idxq = 0;
  endtask

  task automatic test_saturate();
    int exp;
    exp = 0;
    @(negedge clk);
    ins = 4'd13; vs = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (exp < 7) exp++;
      n_checks++; if (cs !== 3'(exp)) $display("FAIL sat_cnt cyc=%0d got %0d want %0d", k, cs, exp); else n_pass++;
    end
    @(negedge clk);
    vs = 1'b0;
  endtask

  task automatic test_width8();
    int hits, cnt;
    hits = 0;
    cnt  = 0;
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      in8 = 8'(v); v8 = 1'b1;
      #1;
      n_checks++; if (o8 !== is_fib(v)) $display("FAIL w8_out in=%0d got %b want %b", v, o8, is_fib(v)); else n_pass++;
      if (o8 === 1'b1) hits++;
      @(posedge clk);
      #1;
      if (is_fib(v)) cnt++;
      n_checks++; if (oq8 !== is_fib(v) || c8 !== 8'(cnt)) $display("FAIL w8_reg in=%0d out_q=%b cnt=%0d want %b/%0d", v, oq8, c8, is_fib(v), cnt); else n_pass++;
    end
    n_checks++; if (hits != 13) $display("FAIL w8_hits got %0d want 13", hits); else n_pass++;
    n_checks++; if (c8 !== 8'd13) $display("FAIL w8_total got %0d want 13", c8); else n_pass++;
    @(negedge clk);
    v8 = 1'b0;
  endtask

`ifdef FIBONACCI_INDEX_EN
  task automatic test_index();
    int seq[8];
    seq[0] = 13; seq[1] = 1; seq[2] = 6;
    for (int i = 3; i < 8; i++) seq[i] = int'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in4 = 4'(seq[i]); v4 = 1'b1;
      #1;
      n_checks++; if (fi4 !== 5'(fib_index(seq[i]))) $display("FAIL idx in=%0d got %0d want %0d", seq[i], fi4, fib_index(seq[i])); else n_pass++;
      @(posedge clk);
      #1;
      m_idxq = fib_index(seq[i]);
      n_checks++; if (fiq4 !== 5'(m_idxq)) $display("FAIL idx_q in=%0d got %0d want %0d", seq[i], fiq4, m_idxq); else n_pass++;
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_hold();
    test_random();
    test_async_reset();
    test_saturate();
    test_width8();
`ifdef FIBONACCI_INDEX_EN
    test_index();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fibonacci.md
Name: fibonacci

Overview:
- Fibonacci-number detector for an unsigned WIDTH-bit operand.
- A combinational flag `out` is 1 when `in` is a member of the Fibonacci sequence 0, 1, 1, 2, 3, 5, 8, 13, 21, …
- A registered copy of the flag and a saturating hit counter are provided so the block can sit in a clocked pipeline.
- Used as a classification leaf in datapath and homework-style number-property units.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- CNT_W, 8, width of the hit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- in  input  WIDTH  unsigned operand.
- in_vld  input  1  qualifies `in` for the registered path and the counter.
- out  output  1  combinational: 1 iff `in` is a Fibonacci number.
- out_q  output  1  registered `out`, sampled when in_vld=1.
- out_q_vld  output  1  registered in_vld (1-cycle-delayed valid).
- hit_cnt  output  CNT_W  count of accepted inputs that were Fibonacci numbers.

Behaviour:
- Fibonacci set: F0=0, F1=1, Fn=Fn-1+Fn-2, restricted to values ≤ 2^WIDTH−1.
  - The membership constant table is built at elaboration time (generate/function).
  - No hard-coded 4-bit-only table.
- WIDTH=4 member set: {0,1,2,3,5,8,13}. Non-members: {4,6,7,9,10,11,12,14,15}.
- `out` is purely combinational from `in`:
  - zero latency;
  - independent of clk, rst and in_vld;
  - valid whenever `in` is stable.
- On a rising clk edge with rst=1:
  - out_q_vld <= in_vld.
  - If in_vld=1: out_q <= out. Otherwise out_q holds its value.
  - If in_vld=1 and out=1: hit_cnt <= hit_cnt+1, saturating at 2^CNT_W−1 (no wrap).
- Latency: out_q/out_q_vld appear 1 cycle after the accepting edge. hit_cnt reflects an accepted input 1 cycle after its edge.
- Reset: rst=0 asynchronously forces out_q=0, out_q_vld=0, hit_cnt=0.
  - `out` stays combinational and continues tracking `in` during reset.
- Reset deassertion: registers start updating on the first rising clk edge with rst=1.
- Reset mid-operation: the accumulated count is lost. No state survives reset.
- Unknown/X on `in` propagates to `out`. No internal masking.
- No handshake back-pressure; every cycle with in_vld=1 is accepted.

Optional Feature:
- Macro FIBONACCI_INDEX_EN.
- When defined, adds output `fib_idx` (width 5) and its registered copy `fib_idx_q` (width 5).
  - fib_idx is the smallest n with Fn == in when out=1, else 0.
  - The value 1 maps to n=1, not n=2.
  - WIDTH=4 mapping: 0→0, 1→1, 2→3, 3→4, 5→5, 8→6, 13→7.
  - fib_idx_q updates under the same in_vld rule as out_q and resets to 0.
- When not defined, neither port exists and behaviour is otherwise identical.

Test Plan:
- rst=0 then released, WIDTH=4, sweep in=0..15 one value per cycle with in_vld=1.
  - Required: out=1 exactly for 0,1,2,3,5,8,13.
  - out_q matches the previous cycle's out.
  - hit_cnt=7 after the sweep.
- in=4, in_vld=0 for several cycles → out=0 immediately; out_q, out_q_vld and hit_cnt unchanged.
- Assert rst=0 asynchronously between clock edges with hit_cnt=5.
  - Required: hit_cnt, out_q and out_q_vld go to 0 without a clock.
  - With in=8, out=1 throughout.
- CNT_W=3, hold in=13, in_vld=1 for 10 cycles → hit_cnt saturates at 7 and stays 7.
- WIDTH=8, sweep 0..255 → out=1 only for 0,1,2,3,5,8,13,21,34,55,89,144,233 (13 hits).
- With FIBONACCI_INDEX_EN defined:
  - in=13 → fib_idx=7;
  - in=1 → fib_idx=1;
  - in=6 → fib_idx=0;
  - fib_idx_q follows 1 cycle later.
